// File: rtl/host_cmd_link.sv
// Host-side command/response link: packs three UART bytes into a 24-bit command
// and pushes single response bytes out through the UART transmitter.
//
// state  | meaning
// R_IDLE | no command bytes held
// R_B1   | first (MS) byte held, waiting for the second
// R_B2   | two bytes held, waiting for the last
// R_FULL | command complete, cmd_rdy asserted until cleared
// T_IDLE | response path free
// T_LOAD | byte latched, trmt strobed this cycle
// T_WAIT | transmitter busy, waiting for tx_done
// T_DONE | resp_sent strobed this cycle
module host_cmd_link #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        tx_busy,
  output logic        rx_ovr,
  output logic        rx_tmo
);

  typedef enum logic [1:0] {R_IDLE, R_B1, R_B2, R_FULL} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_WAIT, T_DONE} tx_state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  rx_state_t   rx_state;
  tx_state_t   tx_state;
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_IDLE;
      tmo_cnt  <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_tmo   <= 1'b0;
    end else begin
      rx_ovr <= 1'b0;
      rx_tmo <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          tmo_cnt <= '0;
          if (rx_rdy) begin
            cmd[23:16] <= rx_data;
            rx_state   <= R_B1;
          end
        end
        R_B1: begin
          if (rx_rdy) begin
            cmd[15:8] <= rx_data;
            tmo_cnt   <= '0;
            rx_state  <= R_B2;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt  <= '0;
            rx_tmo   <= 1'b1;
            rx_state <= R_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        R_B2: begin
          if (rx_rdy) begin
            cmd[7:0] <= rx_data;
            tmo_cnt  <= '0;
            cmd_rdy  <= 1'b1;
            rx_state <= R_FULL;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt  <= '0;
            rx_tmo   <= 1'b1;
            rx_state <= R_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        R_FULL: begin
          tmo_cnt <= '0;
          if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            // a byte arriving with the clear starts the next command
            if (rx_rdy) begin
              cmd[23:16] <= rx_data;
              rx_state   <= R_B1;
            end else begin
              rx_state <= R_IDLE;
            end
          end else if (rx_rdy) begin
            rx_ovr <= 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= T_IDLE;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (send_resp) begin
            tx_data  <= resp_data;
            trmt     <= 1'b1;
            tx_busy  <= 1'b1;
            tx_state <= T_LOAD;
          end
        end
        T_LOAD: begin
          trmt     <= 1'b0;
          tx_state <= T_WAIT;
        end
        T_WAIT: begin
          if (tx_done) begin
            resp_sent <= 1'b1;
            tx_state  <= T_DONE;
          end
        end
        T_DONE: begin
          resp_sent <= 1'b0;
          tx_busy   <= 1'b0;
          tx_state  <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_link.sv
// Bench for host_cmd_link: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an event-level reference model.
module tb_host_cmd_link;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp_data = '0;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic        tx_busy;
  logic        rx_ovr;
  logic        rx_tmo;

  host_cmd_link #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .tx_busy(tx_busy), .rx_ovr(rx_ovr),
    .rx_tmo(rx_tmo)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: byte list with an idle-gap counter for RX, and
  // launch/done timestamps for TX. Updated with the inputs of each cycle,
  // yielding the outputs expected in the following cycle.
  int          k_cyc = 0;
  int          m_n, m_gap;
  logic [7:0]  m_b[3];
  bit          m_busy;
  int          m_launch, m_done;
  logic [7:0]  m_data;
  logic [23:0] exp_cmd;
  bit exp_cmd_rdy, exp_rx_ovr, exp_rx_tmo, exp_trmt, exp_resp_sent, exp_tx_busy;
  logic [7:0]  exp_tx_data;

  always @(posedge clk) begin
    int  k;
    bit  busy_k;
    k = k_cyc;
    k_cyc++;
    if (rst) begin
      m_n = 0; m_gap = 0;
      m_b[0] = '0; m_b[1] = '0; m_b[2] = '0;
      m_busy = 0; m_launch = -10; m_done = -1; m_data = '0;
      exp_rx_ovr = 0; exp_rx_tmo = 0; exp_trmt = 0; exp_resp_sent = 0;
    end else begin
      exp_rx_ovr = 0;
      exp_rx_tmo = 0;
      if (m_n == 3) begin
        if (clr_cmd_rdy) begin
          m_n = 0;
          if (rx_rdy) begin
            m_b[0] = rx_data; m_n = 1; m_gap = 0;
          end
        end else if (rx_rdy) begin
          exp_rx_ovr = 1;
        end
      end else if (rx_rdy) begin
        m_b[m_n] = rx_data; m_n++; m_gap = 0;
      end else if (m_n > 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          m_n = 0; m_gap = 0; exp_rx_tmo = 1;
        end
      end

      busy_k = m_busy;
      if (m_busy && m_done >= 0 && k == m_done + 1) m_busy = 0;
      else if (m_busy && m_done < 0 && tx_done && k >= m_launch + 2) m_done = k;
      if (!busy_k && send_resp) begin
        m_busy = 1; m_launch = k; m_data = resp_data; m_done = -1;
      end
      exp_trmt      = m_busy && (k == m_launch);
      exp_resp_sent = m_busy && m_done >= 0 && (k == m_done);
    end
    exp_cmd_rdy = (m_n == 3);
    exp_cmd     = {m_b[0], m_b[1], m_b[2]};
    exp_tx_busy = m_busy;
    exp_tx_data = m_data;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_rdy", 32'(cmd_rdy), 32'(exp_cmd_rdy));
      if (exp_cmd_rdy) chk("cmd", 32'(cmd), 32'(exp_cmd));
      chk("rx_ovr", 32'(rx_ovr), 32'(exp_rx_ovr));
      chk("rx_tmo", 32'(rx_tmo), 32'(exp_rx_tmo));
      chk("trmt", 32'(trmt), 32'(exp_trmt));
      chk("resp_sent", 32'(resp_sent), 32'(exp_resp_sent));
      chk("tx_busy", 32'(tx_busy), 32'(exp_tx_busy));
      chk("tx_data", 32'(tx_data), 32'(exp_tx_data));
    end
  end

  task automatic drive(input logic r, input logic [7:0] d, input logic c,
                       input logic s, input logic [7:0] rd, input logic td);
    rx_rdy = r; rx_data = d; clr_cmd_rdy = c;
    send_resp = s; resp_data = rd; tx_done = td;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    drive(1, d, 0, 0, 8'h00, 0);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_cmd"}, 32'(cmd), 32'h0);
    chk({nm, "_flags"}, 32'({cmd_rdy, rx_ovr, rx_tmo, trmt, resp_sent, tx_busy}), 32'h0);
    chk({nm, "_tx_data"}, 32'(tx_data), 32'h0);
  endtask

  initial begin
    int rx_pct;
    @(negedge clk);
    chk_en = 1'b1;
    idle(1);
    all_zero("reset");
    rst = 1'b0;
    idle(2);

    // basic assembly and clear
    rx_byte(8'h12); rx_byte(8'h34);
    chk("cmd_rdy_after_2", 32'(cmd_rdy), 32'h0);
    rx_byte(8'h56);
    chk("cmd_rdy_set", 32'(cmd_rdy), 32'h1);
    chk("cmd_123456", 32'(cmd), 32'h123456);
    drive(0, 8'h00, 1, 0, 8'h00, 0);
    chk("cmd_rdy_clr", 32'(cmd_rdy), 32'h0);

    // overrun, then clear racing a new first byte
    rx_byte(8'hAB); rx_byte(8'hCD); rx_byte(8'hEF);
    rx_byte(8'h99);
    chk("rx_ovr_pulse", 32'(rx_ovr), 32'h1);
    chk("cmd_kept", 32'(cmd), 32'hABCDEF);
    idle(1);
    chk("rx_ovr_single", 32'(rx_ovr), 32'h0);
    drive(1, 8'h77, 1, 0, 8'h00, 0);
    chk("clr_wins", 32'(cmd_rdy), 32'h0);
    chk("no_ovr_on_clr", 32'(rx_ovr), 32'h0);
    rx_byte(8'h01); rx_byte(8'h02);
    chk("cmd_770102", 32'(cmd), 32'h770102);
    drive(0, 8'h00, 1, 0, 8'h00, 0);

    // timeout after TMO idle cycles
    rx_byte(8'hAA);
    idle(TMO - 1);
    chk("no_tmo_early", 32'(rx_tmo), 32'h0);
    idle(1);
    chk("rx_tmo_pulse", 32'(rx_tmo), 32'h1);
    idle(1);
    chk("rx_tmo_single", 32'(rx_tmo), 32'h0);
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    chk("cmd_112233", 32'(cmd), 32'h112233);
    drive(0, 8'h00, 1, 0, 8'h00, 0);

    // byte arriving on the expiry cycle is accepted
    rx_byte(8'h10); idle(TMO - 1);
    rx_byte(8'h20); idle(TMO - 1);
    rx_byte(8'h30);
    chk("cmd_102030", 32'(cmd), 32'h102030);
    chk("cmd_rdy_edge_gap", 32'(cmd_rdy), 32'h1);
    drive(0, 8'h00, 1, 0, 8'h00, 0);

    // response path
    drive(0, 8'h00, 0, 1, 8'hA5, 0);
    chk("trmt_pulse", 32'(trmt), 32'h1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    idle(1);
    chk("trmt_single", 32'(trmt), 32'h0);
    drive(0, 8'h00, 0, 1, 8'h3C, 0);
    chk("tx_data_held", 32'(tx_data), 32'hA5);
    idle(8);
    drive(0, 8'h00, 0, 0, 8'h00, 1);
    chk("resp_sent_pulse", 32'(resp_sent), 32'h1);
    idle(1);
    chk("resp_sent_single", 32'(resp_sent), 32'h0);
    chk("tx_busy_clear", 32'(tx_busy), 32'h0);

    // reset while both paths are occupied
    drive(0, 8'h00, 0, 1, 8'h5A, 0);
    idle(2);
    rx_byte(8'hC1); rx_byte(8'hC2); rx_byte(8'hC3);
    chk("pre_rst_rdy", 32'(cmd_rdy), 32'h1);
    rst = 1'b1;
    idle(1);
    all_zero("mid_rst");
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 1);
    chk("no_resp_after_rst", 32'(resp_sent), 32'h0);
    idle(1);
    chk("no_resp_after_rst2", 32'(resp_sent), 32'h0);

    // randomized traffic against the model
    rx_pct = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0: rx_pct = 4;
          1: rx_pct = 40;
          default: rx_pct = 90;
        endcase
      end
      rst = ($urandom_range(999) == 0);
      drive(($urandom_range(99) < rx_pct), 8'($urandom),
            ($urandom_range(9) < 3), ($urandom_range(7) == 0), 8'($urandom),
            ($urandom_range(5) == 0));
    end
    rst = 1'b0;
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
